// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// Used by ccff_chain_loader and ccff_guard_checker.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StLoad,
    StDone
  } ccff_state_e;

  // Words needed to cover the chain; the last word may be partially used.
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_guard_checker.sv
// Compares the guard pattern returning on ccff_tail against the pattern that was pushed in.
// Instantiated only when CCFF_TAIL_CHECK_EN is defined; err_o is sticky until clear_i.
module ccff_guard_checker
  import ccff_loader_pkg::*;
#(
  parameter int unsigned          CHAIN_LEN     = 1024,
  parameter int unsigned          GUARD_LEN     = 8,
  parameter logic [GUARD_LEN-1:0] GUARD_PATTERN = 8'hA5,
  parameter int unsigned          KW            = cnt_width(CHAIN_LEN + GUARD_LEN)
) (
  input  logic          prog_clk,
  input  logic          pReset,
  input  logic          clear_i,
  input  logic          shift_en_i,
  input  logic [KW-1:0] k_i,
  input  logic          ccff_tail,
  output logic          err_o
);

  localparam logic [KW-1:0] WinLo = KW'(CHAIN_LEN);
  localparam logic [KW-1:0] WinHi = KW'(CHAIN_LEN + GUARD_LEN);

  logic [KW-1:0]        offset;
  logic [GUARD_LEN-1:0] pat_shifted;
  logic                 in_win;
  logic                 expected_bit;
  logic                 mismatch;
  logic                 err_d, err_q;

  always_comb begin
    offset       = k_i - WinLo;
    // Guard bit i emerges at the tail CHAIN_LEN shifts after it went in.
    pat_shifted  = GUARD_PATTERN << offset;
    expected_bit = pat_shifted[GUARD_LEN-1];
    in_win       = (k_i >= WinLo) && (k_i < WinHi);
    mismatch     = shift_en_i && in_win && (ccff_tail != expected_bit);

    err_d = err_q;
    if (clear_i) begin
      err_d = 1'b0;
    end else if (mismatch) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into a ccff chain and gates its shift clock.
// Define CCFF_TAIL_CHECK_EN to push a guard pattern ahead of the payload and check it at the tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned          CHAIN_LEN     = 1024,
  parameter int unsigned          WORD_W        = 32,
  parameter int unsigned          GUARD_LEN     = 8,
  parameter logic [GUARD_LEN-1:0] GUARD_PATTERN = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_i,
  input  logic [WORD_W-1:0] cfg_word_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned NumWords = num_words(CHAIN_LEN, WORD_W);
  localparam int unsigned LastBits = CHAIN_LEN - (NumWords - 1) * WORD_W;
`ifdef CCFF_TAIL_CHECK_EN
  localparam int unsigned PreLen   = GUARD_LEN;
`else
  localparam int unsigned PreLen   = 0;
`endif
  localparam int unsigned TotalShifts = PreLen + CHAIN_LEN;
  localparam int unsigned KWidth      = cnt_width(TotalShifts);
  localparam int unsigned WordCntW    = cnt_width(NumWords);
  localparam int unsigned BitCntW     = cnt_width(WORD_W);

  localparam logic [KWidth-1:0]   KLast    = KWidth'(TotalShifts - 1);
  localparam logic [WordCntW-1:0] WordsMax = WordCntW'(NumWords);
  localparam logic [WordCntW-1:0] WordLast = WordCntW'(NumWords - 1);
  localparam logic [BitCntW-1:0]  BitsFull = BitCntW'(WORD_W);
  localparam logic [BitCntW-1:0]  BitsLast = BitCntW'(LastBits);
  localparam logic [BitCntW-1:0]  BitOne   = BitCntW'(1);

  ccff_state_e         state_d, state_q;
  logic [WORD_W-1:0]   buf_d, buf_q;
  logic [BitCntW-1:0]  bit_cnt_d, bit_cnt_q;
  logic [WordCntW-1:0] word_cnt_d, word_cnt_q;
  logic [KWidth-1:0]   k_d, k_q;
  logic                shift_en;
  logic                start_acc;
  logic                ready;
  logic                head;

`ifdef CCFF_TAIL_CHECK_EN
  localparam logic [KWidth-1:0] KGuardLast = KWidth'(GUARD_LEN - 1);
  logic [GUARD_LEN-1:0] guard_d, guard_q;
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    k_d        = k_q;
    shift_en   = 1'b0;
    start_acc  = 1'b0;
    ready      = 1'b0;
    head       = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
    guard_d    = guard_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_acc  = 1'b1;
          buf_d      = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          k_d        = '0;
`ifdef CCFF_TAIL_CHECK_EN
          guard_d    = GUARD_PATTERN;
          state_d    = StGuard;
`else
          state_d    = StLoad;
`endif
        end
      end
`ifdef CCFF_TAIL_CHECK_EN
      StGuard: begin
        shift_en = 1'b1;
        head     = guard_q[GUARD_LEN-1];
        guard_d  = guard_q << 1;
        k_d      = k_q + KWidth'(1);
        if (k_q == KGuardLast) begin
          state_d = StLoad;
        end
      end
`endif
      StLoad: begin
        shift_en = (bit_cnt_q != '0);
        head     = buf_q[WORD_W-1];
        // Accept while the last buffered bit leaves so words stream without a bubble.
        ready    = (word_cnt_q < WordsMax) && (bit_cnt_q <= BitOne);
        if (shift_en) begin
          buf_d     = buf_q << 1;
          bit_cnt_d = bit_cnt_q - BitOne;
          k_d       = k_q + KWidth'(1);
          if (k_q == KLast) begin
            state_d = StDone;
          end
        end
        if (ready && cfg_valid_i) begin
          buf_d      = cfg_word_i;
          bit_cnt_d  = (word_cnt_q == WordLast) ? BitsLast : BitsFull;
          word_cnt_d = word_cnt_q + WordCntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      k_q        <= k_d;
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      guard_q <= '0;
    end else begin
      guard_q <= guard_d;
    end
  end

  ccff_guard_checker #(
    .CHAIN_LEN    (CHAIN_LEN),
    .GUARD_LEN    (GUARD_LEN),
    .GUARD_PATTERN(GUARD_PATTERN),
    .KW           (KWidth)
  ) u_guard_checker (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .clear_i   (start_acc),
    .shift_en_i(shift_en),
    .k_i       (k_q),
    .ccff_tail (ccff_tail),
    .err_o     (err_o)
  );
`else
  logic unused_sig;
  assign unused_sig = ^{ccff_tail, GUARD_PATTERN, start_acc};
  assign err_o      = 1'b0;
`endif

  assign cfg_ready_o   = ready;
  assign ccff_head     = head;
  assign prog_clk_en_o = shift_en;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);

endmodule
